// File: rtl/simplez_io_defs_pkg.sv
// Shared definitions for the simplez serial I/O blocks:
// transmitter FSM encoding, UART framing constants, board default baud.
package simplez_io_defs_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_t;

   localparam int DATA_BITS    = 8;
   localparam int STOP_BITS    = 1;

   // 12 MHz clock / 115200 baud
   localparam int DEF_BAUD_DIV = 104;

endpackage

// File: rtl/simplez_baud_gen.sv
// Bit-period counter shared by the simplez UART blocks.
// Ports: clk, rstn (async low), clr (restart period), en (count),
//        tick (one-cycle pulse on the last cycle of each bit period).
module simplez_baud_gen
   import simplez_io_defs_pkg::*;
#(
   parameter int BAUD_DIV = DEF_BAUD_DIV,
   parameter int CNT_W    = 16
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = en & (cnt == LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/simplez_uart_tx.sv
// 8N1 LSB-first UART transmitter with a one-byte holding register.
// Ports: clk, rstn (async low), data/wr (byte write), ready (hold empty),
//        busy (frame on line), tx (registered serial output, idle high).
module simplez_uart_tx
   import simplez_io_defs_pkg::*;
#(
   parameter int BAUD_DIV = DEF_BAUD_DIV,
   parameter int CNT_W    = 16
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] data,
   input  logic       wr,
   output logic       ready,
   output logic       busy,
   output logic       tx
);

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   tx_state_t  state_q, state_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] hold_q, hold_d;
   logic [2:0] idx_q, idx_d;
   logic       hold_valid_q, hold_valid_d;
   logic       tx_q, tx_d;
   logic       load;
   logic       tick;

   simplez_baud_gen #(
      .BAUD_DIV (BAUD_DIV),
      .CNT_W    (CNT_W)
   ) u_baud (
      .clk  (clk),
      .rstn (rstn),
      .clr  (load),
      .en   (state_q != S_IDLE),
      .tick (tick)
   );

   assign ready = ~hold_valid_q;
   assign busy  = (state_q != S_IDLE);
   assign tx    = tx_q;

   always_comb begin
      state_d      = state_q;
      shift_d      = shift_q;
      hold_d       = hold_q;
      idx_d        = idx_q;
      hold_valid_d = hold_valid_q;
      tx_d         = tx_q;
      load         = 1'b0;

      // A write is only taken while the holding register is empty,
      // so it can never collide with a frame load below.
      if (wr && !hold_valid_q) begin
         hold_d       = data;
         hold_valid_d = 1'b1;
      end

      unique case (state_q)
         S_IDLE: begin
            if (hold_valid_q) load = 1'b1;
         end
         S_START: begin
            if (tick) begin
               state_d = S_DATA;
               tx_d    = shift_q[0];
               idx_d   = 3'd0;
            end
         end
         S_DATA: begin
            if (tick) begin
               if (idx_q == LAST_BIT) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  shift_d = shift_q >> 1;
                  idx_d   = idx_q + 3'd1;
                  tx_d    = shift_q[1];
               end
            end
         end
         S_STOP: begin
            // Chain straight into the next start bit when a byte waits.
            if (tick) begin
               if (hold_valid_q) load = 1'b1;
               else              state_d = S_IDLE;
            end
         end
         default: ;
      endcase

      if (load) begin
         shift_d      = hold_q;
         hold_valid_d = 1'b0;
         tx_d         = 1'b0;
         state_d      = S_START;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         shift_q      <= '0;
         hold_q       <= '0;
         idx_q        <= '0;
         hold_valid_q <= 1'b0;
         tx_q         <= 1'b1;
      end else begin
         state_q      <= state_d;
         shift_q      <= shift_d;
         hold_q       <= hold_d;
         idx_q        <= idx_d;
         hold_valid_q <= hold_valid_d;
         tx_q         <= tx_d;
      end
   end

endmodule

// File: tb/tb_simplez_uart_tx.sv
// Self-checking bench for simplez_uart_tx at BAUD_DIV 4, 2 and 104.
// Frame-level reference model per instance plus directed literal checks.
module tb_simplez_uart_tx;

   localparam int NI = 3;
   localparam int DIVS [NI] = '{4, 2, 104};

   logic       clk  = 1'b0;
   logic       rstn = 1'b0;
   logic       wr    [NI];
   logic [7:0] data  [NI];
   logic       ready [NI];
   logic       busy  [NI];
   logic       tx    [NI];

   int checks = 0;
   int errors = 0;

   bit cap_tx [$];
   bit cap_busy [$];
   bit cap_rdy [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : inst
      localparam int D = DIVS[g];

      simplez_uart_tx #(
         .BAUD_DIV (D),
         .CNT_W    (16)
      ) dut (
         .clk   (clk),
         .rstn  (rstn),
         .data  (data[g]),
         .wr    (wr[g]),
         .ready (ready[g]),
         .busy  (busy[g]),
         .tx    (tx[g])
      );

      // Model: a frame is 10*D cycles long, indexed by time t since load.
      logic       m_act, m_hv;
      int         m_t;
      logic [7:0] m_hold, m_byte;

      always @(posedge clk or negedge rstn) begin : model
         logic       nact, nhv;
         int         nt;
         logic [7:0] nhold, nbyte;
         if (!rstn) begin
            m_act  <= 1'b0;
            m_hv   <= 1'b0;
            m_t    <= 0;
            m_hold <= 8'h00;
            m_byte <= 8'h00;
         end else begin
            nact  = m_act;
            nhv   = m_hv;
            nt    = m_t;
            nhold = m_hold;
            nbyte = m_byte;
            if (nact) begin
               nt = nt + 1;
               if (nt == 10 * D) nact = 1'b0;
            end
            if (m_hv && !nact) begin
               nact  = 1'b1;
               nt    = 0;
               nbyte = m_hold;
               nhv   = 1'b0;
            end else if (wr[g] && !m_hv) begin
               nhv   = 1'b1;
               nhold = data[g];
            end
            m_act  <= nact;
            m_hv   <= nhv;
            m_t    <= nt;
            m_hold <= nhold;
            m_byte <= nbyte;
         end
      end

      always @(negedge clk) begin : cmp
         int   bitn;
         logic etx;
         bitn = m_t / D;
         etx  = 1'b1;
         if (m_act) begin
            if (bitn == 0)      etx = 1'b0;
            else if (bitn <= 8) etx = m_byte[bitn-1];
         end
         checks++;
         if (tx[g] !== etx || busy[g] !== m_act || ready[g] !== !m_hv) begin
            errors++;
            $display("FAIL cmp_div%0d @%0t tx/busy/ready got %b%b%b want %b%b%b",
                     D, $time, tx[g], busy[g], ready[g], etx, m_act, !m_hv);
         end
      end
   end

   task automatic check(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, got, exp);
      end
   endtask

   task automatic send(input int g, input logic [7:0] b);
      wr[g]   = 1'b1;
      data[g] = b;
      @(negedge clk);
      wr[g]   = 1'b0;
   endtask

   task automatic wait_ready(input int g, input int budget);
      int k = 0;
      while (!ready[g] && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (!ready[g]) begin
         errors++;
         $display("FAIL wait_ready timeout inst %0d got 0 want 1", g);
      end
   endtask

   task automatic capture(input int g, input int n);
      cap_tx.delete();
      cap_busy.delete();
      cap_rdy.delete();
      repeat (n) begin
         @(negedge clk);
         cap_tx.push_back(tx[g]);
         cap_busy.push_back(busy[g]);
         cap_rdy.push_back(ready[g]);
      end
   endtask

   function automatic logic [7:0] decode(input int s, input int d);
      logic [7:0] b = 8'h00;
      for (int i = 0; i < 8; i++) begin
         int k = s + d * (i + 1) + d / 2;
         if (k < cap_tx.size()) b[i] = cap_tx[k];
      end
      return b;
   endfunction

   function automatic int busy_cnt();
      int c = 0;
      foreach (cap_busy[i]) if (cap_busy[i]) c++;
      return c;
   endfunction

   function automatic int low_cnt();
      int c = 0;
      foreach (cap_tx[i]) if (!cap_tx[i]) c++;
      return c;
   endfunction

   task automatic runs(output int lo, output int hi);
      int i = 0;
      lo = 0;
      hi = 0;
      while (i < cap_tx.size() && !cap_tx[i]) begin lo++; i++; end
      while (i < cap_tx.size() && cap_tx[i]) begin hi++; i++; end
   endtask

   initial begin
      logic [9:0] frame;
      int lo, hi;

      for (int g = 0; g < NI; g++) begin
         wr[g]   = 1'b0;
         data[g] = 8'h00;
      end

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_tx", tx[0], 1);
      check("reset_ready", ready[0], 1);
      check("reset_busy", busy[0], 0);
      #2 rstn = 1'b1;
      repeat (3) @(negedge clk);

      // Single byte 0x55
      send(0, 8'h55);
      check("accept_ready_low", ready[0], 0);
      check("accept_tx_idle", tx[0], 1);
      capture(0, 44);
      check("load_ready_back", cap_rdy[0], 1);
      frame = '0;
      for (int i = 0; i < 10; i++) frame[i] = cap_tx[4 * i + 2];
      check("frame_55", frame, 10'h2AA);
      check("busy_len_55", busy_cnt(), 40);
      check("after_55_idle", cap_tx[40], 1);

      // Back-to-back 0xA3, 0x0F
      send(0, 8'hA3);
      fork
         capture(0, 84);
         begin
            wait_ready(0, 20);
            send(0, 8'h0F);
         end
      join
      check("b2b_first", decode(0, 4), 8'hA3);
      check("b2b_second", decode(40, 4), 8'h0F);
      check("b2b_no_gap", cap_tx[40], 0);
      check("b2b_busy", busy_cnt(), 80);

      // Overrun: third write while the holding register is full
      send(0, 8'h11);
      fork
         capture(0, 90);
         begin
            wait_ready(0, 20);
            send(0, 8'h22);
            send(0, 8'h33);
         end
      join
      check("ovr_first", decode(0, 4), 8'h11);
      check("ovr_second", decode(40, 4), 8'h22);
      check("ovr_busy", busy_cnt(), 80);
      check("ovr_dropped", cap_busy[85], 0);

      // Reset in bit 3 of 0xFF with 0x00 waiting in hold
      send(0, 8'hFF);
      wait_ready(0, 20);
      send(0, 8'h00);
      repeat (15) @(negedge clk);
      check("pre_rst_busy", busy[0], 1);
      #2 rstn = 1'b0;
      #1;
      check("rst_tx", tx[0], 1);
      check("rst_ready", ready[0], 1);
      check("rst_busy", busy[0], 0);
      repeat (3) @(negedge clk);
      #2 rstn = 1'b1;
      capture(0, 60);
      check("post_rst_busy", busy_cnt(), 0);
      check("post_rst_low", low_cnt(), 0);
      send(0, 8'h5A);
      capture(0, 44);
      check("post_rst_5a", decode(0, 4), 8'h5A);
      check("post_rst_len", busy_cnt(), 40);

      // Bit widths at BAUD_DIV 2 and 104
      send(1, 8'h81);
      capture(1, 24);
      runs(lo, hi);
      check("div2_byte", decode(0, 2), 8'h81);
      check("div2_frame", busy_cnt(), 20);
      check("div2_start_w", lo, 2);
      check("div2_bit0_w", hi, 2);

      send(2, 8'h81);
      capture(2, 1050);
      runs(lo, hi);
      check("div104_byte", decode(0, 104), 8'h81);
      check("div104_frame", busy_cnt(), 1040);
      check("div104_start_w", lo, 104);
      check("div104_bit0_w", hi, 104);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
